wave_capture: RTL and testbench
===============================

Name: wave_capture

Overview:
Triggered capture buffer that sits on the receiving end of the sample-generator stream.
- Accepts a stream of 12-bit samples with a valid strobe.
- Waits for a level-crossing trigger, then stores DEPTH consecutive samples in an internal RAM.
- Flags completion; the display/plot logic then reads the stored trace through a synchronous random-access read port.

Parameters:
DEPTH, 400, number of samples stored per capture (one per screen column).
DATA_W, 12, sample width in bits.
ADDR_W, 9, address width for write pointer and read port; must satisfy 2**ADDR_W >= DEPTH.

Ports:
clk  input  1  single system clock, all logic on rising edge.
rst  input  1  synchronous, active-high reset.
in_data  input  DATA_W  incoming sample, unsigned.
in_valid  input  1  in_data valid this cycle; no backpressure, samples are never stalled.
trig_level  input  DATA_W  trigger threshold, unsigned.
trig_rising  input  1  1 = rising-edge trigger, 0 = falling-edge trigger.
arm  input  1  single-cycle pulse: start/restart a capture.
force_trig  input  1  single-cycle pulse: trigger immediately while ARMED.
rd_addr  input  ADDR_W  read address from the display side.
rd_data  output  DATA_W  registered read data.
busy  output  1  high in ARMED or CAPTURE.
ready  output  1  high in DONE; a complete trace is held.

Behaviour:
Reset values:
- state IDLE; busy 0, ready 0, rd_data 0.
- Write pointer 0; previous-sample register 0; prev_ok flag 0.
- RAM contents are not cleared.

State machine: IDLE, ARMED, CAPTURE, DONE.
- busy and ready are decoded from the registered state (busy = ARMED|CAPTURE, ready = DONE), so they are glitch-free.
- IDLE: in_valid ignored. arm -> ARMED.
- ARMED, on each in_valid:
  - Rising trigger: prev_ok && prev < trig_level && in_data >= trig_level.
  - Falling trigger: prev_ok && prev > trig_level && in_data <= trig_level.
  - All compares are unsigned.
  - After the compare, prev <= in_data and prev_ok <= 1.
  - The first valid sample after arm only loads prev and can never trigger.
- Trigger (edge or force_trig) in ARMED:
  - If in_valid in the same cycle, the trigger sample is written to address 0 and the pointer goes to 1.
  - If force_trig occurs with in_valid low, the pointer stays 0 and the next valid sample lands at 0.
  - Next state is CAPTURE.
  - force_trig is ignored in IDLE, CAPTURE and DONE.
- CAPTURE:
  - Each in_valid writes RAM[ptr] <= in_data, then ptr++.
  - Cycles with in_valid low write nothing.
  - The write at ptr == DEPTH-1 moves the FSM to DONE; ready rises the following cycle.
  - The pointer never wraps inside a capture.
- DONE: in_valid ignored; RAM is frozen. arm -> ARMED.
- arm in ARMED or CAPTURE (restart):
  - Next state ARMED; ptr <= 0; prev_ok <= 0.
  - The partial capture is abandoned.
  - arm takes priority over a trigger or a final write in the same cycle.
- rst at any time (including mid-capture) forces the reset values on the next edge.

Read port:
- Always active, in every state.
- rd_data <= RAM[rd_addr] one cycle after rd_addr is presented.
- rd_addr >= DEPTH returns 0.
- A read and a write to the same address in the same cycle returns the old data (read-first).

Implementation:
- RAM is single-write / single-read and must infer as block RAM.
- No combinational path from any input to any output.

Test Plan:
1. Reset: assert rst 2 cycles with random inputs -> busy 0, ready 0, rd_data 0; in_valid activity does not leave IDLE.
2. Rising trigger: trig_level 100, trig_rising 1, arm, then feed ramp 0..511 with in_valid every cycle.
   - Trigger occurs on 99->100; busy stays 1 until ready.
   - ready asserts exactly one cycle after sample 499 is written.
   - rd_addr 0/1/399 -> rd_data 100/101/499 one cycle later.
   - rd_addr 400 -> 0.
3. Falling trigger: trig_level 2000, trig_rising 0, descending ramp from 4095 with in_valid high on alternate cycles -> RAM[0]=2000, RAM[399]=1601; ready asserts after 400 valid samples.
4. First-sample rule: trig_level 100, arm, feed 150, 90, 120 -> no trigger on 150 (no prev); trigger on 90->120; RAM[0]=120.
5. force_trig: arm, constant 50 (never crosses 100), force_trig with in_valid low -> next valid sample at RAM[0]. Repeat with in_valid high -> that sample at RAM[0]. Both end with ready after 400 valid samples.
6. Restart/reset:
   - arm after 50 captured samples -> state ARMED, ready 0, new capture starts at address 0.
   - arm coincident with the 400th write -> ARMED, ready never asserts.
   - rst mid-CAPTURE -> IDLE; busy 0 next cycle.

Source files
------------

// File: rtl/wave_capture.sv
// wave_capture: triggered capture buffer for a 12-bit sample stream.
//   Waits for a level-crossing trigger (or a forced trigger), stores DEPTH
//   consecutive valid samples in a block RAM, then holds the trace for a
//   synchronous random-access read port.
// Ports:
//   clk, rst          - system clock, synchronous active-high reset
//   in_data, in_valid - incoming sample stream (no backpressure)
//   trig_level        - unsigned trigger threshold
//   trig_rising       - 1 = rising crossing, 0 = falling crossing
//   arm               - pulse: start or restart a capture
//   force_trig        - pulse: trigger immediately while armed
//   rd_addr, rd_data  - registered read port (one-cycle latency)
//   busy, ready       - ARMED|CAPTURE, DONE
module wave_capture #(
  parameter int DEPTH  = 400,
  parameter int DATA_W = 12,
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] trig_level,
  input  logic              trig_rising,
  input  logic              arm,
  input  logic              force_trig,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              ready
);

  typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DONE} state_e;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [DATA_W-1:0]   prev_q, prev_d;
  logic                prev_ok_q, prev_ok_d;
  logic                rd_ok_q, rd_ok_d;
  logic                we_d;
  logic                rise_hit, fall_hit, edge_hit;

  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic [DATA_W-1:0]   mem_rd_q;

  // Crossing detect against the previous valid sample; prev_ok gates out the
  // first sample after arm, which has nothing to compare against.
  always_comb begin
    rise_hit = prev_ok_q && (prev_q < trig_level) && (in_data >= trig_level);
    fall_hit = prev_ok_q && (prev_q > trig_level) && (in_data <= trig_level);
    edge_hit = in_valid && (trig_rising ? rise_hit : fall_hit);
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    prev_d    = prev_q;
    prev_ok_d = prev_ok_q;
    we_d      = 1'b0;
    rd_ok_d   = (rd_addr <= LAST);
    unique case (state_q)
      IDLE: begin
        if (arm) begin
          state_d   = ARMED;
          ptr_d     = '0;
          prev_ok_d = 1'b0;
        end
      end
      ARMED: begin
        if (arm) begin
          ptr_d     = '0;
          prev_ok_d = 1'b0;
        end else begin
          if (in_valid) begin
            prev_d    = in_data;
            prev_ok_d = 1'b1;
          end
          if (force_trig || edge_hit) begin
            state_d = CAPTURE;
            // The trigger sample itself is the first stored sample; ptr is
            // already 0 here because every entry into ARMED clears it.
            if (in_valid) begin
              we_d  = 1'b1;
              ptr_d = ptr_q + ADDR_W'(1);
            end
          end
        end
      end
      CAPTURE: begin
        if (arm) begin
          state_d   = ARMED;
          ptr_d     = '0;
          prev_ok_d = 1'b0;
        end else if (in_valid) begin
          we_d  = 1'b1;
          ptr_d = ptr_q + ADDR_W'(1);
          if (ptr_q == LAST) state_d = DONE;
        end
      end
      DONE: begin
        if (arm) begin
          state_d   = ARMED;
          ptr_d     = '0;
          prev_ok_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      prev_q    <= '0;
      prev_ok_q <= 1'b0;
      rd_ok_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      prev_q    <= prev_d;
      prev_ok_q <= prev_ok_d;
      rd_ok_q   <= rd_ok_d;
    end
  end

  // Plain RAM process (no reset) so it maps to block RAM; the read happens in
  // the same process as the write, giving read-first behaviour.
  always_ff @(posedge clk) begin
    if (we_d) mem_q[ptr_q] <= in_data;
    if (rd_addr <= LAST) mem_rd_q <= mem_q[rd_addr];
  end

  // Out-of-range addresses and reset are handled by a registered qualifier so
  // the RAM output register itself stays reset-free.
  assign rd_data = rd_ok_q ? mem_rd_q : '0;
  assign busy    = (state_q == ARMED) || (state_q == CAPTURE);
  assign ready   = (state_q == DONE);

endmodule

// File: tb/tb_wave_capture.sv
// Directed bench for wave_capture: vector table for reset and the
// first-sample/read-first cases, hand-written loops for the long captures.
module tb_wave_capture;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] in_data;
  logic        in_valid;
  logic [11:0] trig_level;
  logic        trig_rising;
  logic        arm;
  logic        force_trig;
  logic [8:0]  rd_addr;
  logic [11:0] rd_data;
  logic        busy;
  logic        ready;

  int checks   = 0;
  int failures = 0;

  wave_capture dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .trig_level(trig_level), .trig_rising(trig_rising), .arm(arm),
    .force_trig(force_trig), .rd_addr(rd_addr), .rd_data(rd_data),
    .busy(busy), .ready(ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, arm, frc, vld;
    logic [11:0] dat;
    logic [8:0]  ra;
    logic        e_busy, e_ready;
    logic [11:0] e_rd;
  } vec_t;

  vec_t vt [13];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic run_rows(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      rst = vt[i].rst; arm = vt[i].arm; force_trig = vt[i].frc;
      in_valid = vt[i].vld; in_data = vt[i].dat; rd_addr = vt[i].ra;
      tick();
      chk($sformatf("row%0d_busy", i), int'(busy), int'(vt[i].e_busy));
      chk($sformatf("row%0d_ready", i), int'(ready), int'(vt[i].e_ready));
      chk($sformatf("row%0d_rd", i), int'(rd_data), int'(vt[i].e_rd));
    end
    rst = 0; arm = 0; force_trig = 0; in_valid = 0;
  endtask

  task automatic pulse_arm();
    arm = 1; in_valid = 0; tick(); arm = 0;
  endtask

  task automatic rd_chk(input string name, input int addr, input int exp);
    in_valid = 0; rd_addr = 9'(addr); tick();
    chk(name, int'(rd_data), exp);
  endtask

  initial begin
    //          rst arm frc vld dat    ra   busy rdy rd
    vt[0]  = '{1'b1, 1'b1, 1'b1, 1'b1, 12'd3000, 9'd5,   1'b0, 1'b0, 12'd0};
    vt[1]  = '{1'b1, 1'b0, 1'b0, 1'b1, 12'd77,   9'd400, 1'b0, 1'b0, 12'd0};
    vt[2]  = '{1'b0, 1'b0, 1'b1, 1'b1, 12'd200,  9'd400, 1'b0, 1'b0, 12'd0};
    vt[3]  = '{1'b0, 1'b0, 1'b0, 1'b1, 12'd50,   9'd511, 1'b0, 1'b0, 12'd0};
    // first-sample rule, starting from DONE of the falling capture
    vt[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 12'd0,    9'd0,   1'b1, 1'b0, 12'd2000};
    vt[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 12'd150,  9'd0,   1'b1, 1'b0, 12'd2000};
    vt[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 12'd90,   9'd0,   1'b1, 1'b0, 12'd2000};
    vt[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 12'd120,  9'd0,   1'b1, 1'b0, 12'd2000};
    vt[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 12'd0,    9'd0,   1'b1, 1'b0, 12'd120};
    vt[9]  = '{1'b0, 1'b0, 1'b0, 1'b1, 12'd130,  9'd1,   1'b1, 1'b0, 12'd1999};
    vt[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 12'd0,    9'd1,   1'b1, 1'b0, 12'd130};
    vt[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 12'd0,    9'd400, 1'b1, 1'b0, 12'd0};
    vt[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 12'd0,    9'd511, 1'b1, 1'b0, 12'd0};

    rst = 1; arm = 0; force_trig = 0; in_valid = 0; in_data = 0;
    rd_addr = 0; trig_level = 12'd100; trig_rising = 1;

    // 1. reset and IDLE behaviour
    run_rows(0, 3);

    // 2. rising trigger on a 0..511 ramp
    pulse_arm();
    chk("t2_armed_busy", int'(busy), 1);
    rd_addr = 0;
    for (int v = 0; v < 512; v++) begin
      in_valid = 1; in_data = 12'(v); tick();
      chk($sformatf("t2_state_v%0d", v), int'({busy, ready}), (v >= 499) ? 1 : 2);
    end
    rd_chk("t2_rd0", 0, 100);
    rd_chk("t2_rd1", 1, 101);
    rd_chk("t2_rd399", 399, 499);
    rd_chk("t2_rd400", 400, 0);

    // 3. falling trigger, descending ramp, valid on alternate cycles
    trig_level = 12'd2000; trig_rising = 0;
    pulse_arm();
    for (int v = 4095; v >= 1601; v--) begin
      in_valid = 1; in_data = 12'(v); tick();
      chk($sformatf("t3_state_v%0d", v), int'({busy, ready}), (v == 1601) ? 1 : 2);
      in_valid = 0; tick();
      if (v == 1601 || v == 1602)
        chk($sformatf("t3_hold_v%0d", v), int'({busy, ready}), (v == 1601) ? 1 : 2);
    end
    rd_chk("t3_rd0", 0, 2000);
    rd_chk("t3_rd399", 399, 1601);

    // 4. first valid sample after arm cannot trigger; read-first
    trig_level = 12'd100; trig_rising = 1;
    run_rows(4, 12);

    // 5a. force_trig with in_valid low
    pulse_arm();
    for (int k = 0; k < 3; k++) begin in_valid = 1; in_data = 12'd50; tick(); end
    force_trig = 1; in_valid = 0; tick(); force_trig = 0;
    chk("t5a_busy", int'(busy), 1);
    for (int k = 0; k < 400; k++) begin
      in_valid = 1; in_data = 12'(1000 + k); tick();
      if (k >= 398) chk($sformatf("t5a_k%0d", k), int'({busy, ready}), (k == 399) ? 1 : 2);
    end
    rd_chk("t5a_rd0", 0, 1000);
    rd_chk("t5a_rd399", 399, 1399);

    // 5b. force_trig together with a valid sample
    pulse_arm();
    for (int k = 0; k < 3; k++) begin in_valid = 1; in_data = 12'd50; tick(); end
    force_trig = 1; in_valid = 1; in_data = 12'd2000; tick(); force_trig = 0;
    for (int k = 1; k < 400; k++) begin
      in_valid = 1; in_data = 12'(2000 + k); tick();
      if (k >= 398) chk($sformatf("t5b_k%0d", k), int'({busy, ready}), (k == 399) ? 1 : 2);
    end
    rd_chk("t5b_rd0", 0, 2000);
    rd_chk("t5b_rd399", 399, 2399);

    // 6a. restart after 50 captured samples
    pulse_arm();
    force_trig = 1; in_valid = 1; in_data = 12'd3000; tick(); force_trig = 0;
    for (int k = 1; k < 50; k++) begin in_valid = 1; in_data = 12'(3000 + k); tick(); end
    pulse_arm();
    chk("t6a_rearm", int'({busy, ready}), 2);
    force_trig = 1; in_valid = 1; in_data = 12'd500; rd_addr = 1; tick(); force_trig = 0;
    chk("t6a_rd1_old", int'(rd_data), 3001);
    rd_chk("t6a_rd0_new", 0, 500);

    // 6b. arm coincident with the 400th write
    for (int k = 1; k < 399; k++) begin in_valid = 1; in_data = 12'(500 + k); tick(); end
    arm = 1; in_valid = 1; in_data = 12'd899; tick(); arm = 0; in_valid = 0;
    chk("t6b_arm_last", int'({busy, ready}), 2);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("t6b_hold%0d", k), int'({busy, ready}), 2);
    end

    // 6c. reset mid-capture, then force_trig ignored in IDLE
    force_trig = 1; in_valid = 1; in_data = 12'd7; tick(); force_trig = 0;
    for (int k = 0; k < 5; k++) begin in_valid = 1; in_data = 12'(8 + k); tick(); end
    rst = 1; rd_addr = 0; tick(); rst = 0;
    chk("t6c_rst_state", int'({busy, ready}), 0);
    chk("t6c_rst_rd", int'(rd_data), 0);
    force_trig = 1; in_valid = 1; in_data = 12'd300; tick(); force_trig = 0;
    chk("t6c_idle_force", int'({busy, ready}), 0);
    in_valid = 0; tick();
    chk("t6c_idle_stay", int'({busy, ready}), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
